axi4l_mem_slave: RTL

Synthesisable, parametrised AXI4-Lite memory slave that replaces the behavioural testbench memory behind `picorv32_axi`. Width, depth and read latency are generic, and the write channels are fully decoupled. Two MMIO registers are decoded: a console byte port and a test-pass flag. The block sits between the core's AXI master port and the top-level test harness, and is usable in both simulation and FPGA builds.

---
 rtl/axi4l_mem_slave_if.sv | 55 +++++
 rtl/axi4l_mem_slave.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/axi4l_mem_slave_if.sv
// AXI4-Lite bus bundle between the picorv32_axi master port and axi4l_mem_slave.
interface axi4l_mem_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_axi_awvalid;
    logic              mem_axi_awready;
    logic [ADDR_W-1:0] mem_axi_awaddr;
    logic [2:0]        mem_axi_awprot;

    logic              mem_axi_wvalid;
    logic              mem_axi_wready;
    logic [DATA_W-1:0] mem_axi_wdata;
    logic [DATA_W/8-1:0] mem_axi_wstrb;

    logic              mem_axi_bvalid;
    logic              mem_axi_bready;
    logic [1:0]        mem_axi_bresp;

    logic              mem_axi_arvalid;
    logic              mem_axi_arready;
    logic [ADDR_W-1:0] mem_axi_araddr;
    logic [2:0]        mem_axi_arprot;

    logic              mem_axi_rvalid;
    logic              mem_axi_rready;
    logic [DATA_W-1:0] mem_axi_rdata;
    logic [1:0]        mem_axi_rresp;

    modport slave (
        input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
        output mem_axi_awready,
        input  mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
        output mem_axi_wready,
        output mem_axi_bvalid, mem_axi_bresp,
        input  mem_axi_bready,
        input  mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
        output mem_axi_arready,
        output mem_axi_rvalid, mem_axi_rdata, mem_axi_rresp,
        input  mem_axi_rready
    );

    modport master (
        output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
        input  mem_axi_awready,
        output mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
        input  mem_axi_wready,
        input  mem_axi_bvalid, mem_axi_bresp,
        output mem_axi_bready,
        output mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
        input  mem_axi_arready,
        input  mem_axi_rvalid, mem_axi_rdata, mem_axi_rresp,
        output mem_axi_rready
    );
endinterface

// File: rtl/axi4l_mem_slave.sv
// AXI4-Lite memory slave with console-byte and test-pass MMIO registers for picorv32_axi.
// Define AXI4L_MEM_ERR_RESP_EN to answer out-of-range accesses with SLVERR instead of wrapping.
module axi4l_mem_slave #(
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 32,
    parameter int                DEPTH        = 32768,
    parameter int                READ_LAT     = 1,
    parameter logic [ADDR_W-1:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] PASS_ADDR    = 32'h2000_0000,
    parameter logic [31:0]       PASS_MAGIC   = 32'd123456789,
    parameter                    INIT_FILE    = ""
) (
    input  logic                    clk,
    input  logic                    reset,
    axi4l_mem_slave_if.slave        bus,
    output logic                    console_valid,
    output logic [7:0]              console_data,
    output logic                    tests_passed
);
    localparam int BYTES = DATA_W / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW1   = ADDR_W + 1;
    localparam logic [ADDR_W:0] MEM_BYTES = AW1'(DEPTH) * AW1'(BYTES);
    localparam int CNT_W = (READ_LAT > 2) ? $clog2(READ_LAT - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((READ_LAT > 1) ? READ_LAT - 2 : 0);

`ifdef AXI4L_MEM_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rState_t;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              r_awHeld;
    logic [ADDR_W-1:0] r_awAddr;
    logic              r_wHeld;
    logic [DATA_W-1:0] r_wData;
    logic [BYTES-1:0]  r_wStrb;
    logic              r_bValid;
    logic [1:0]        r_bResp;
    logic              r_consoleValid;
    logic [7:0]        r_consoleData;
    logic              r_testsPassed;

    logic              w_awReady;
    logic              w_wReady;
    logic              w_commit;
    logic              w_awConsole;
    logic              w_awPass;
    logic              w_awInRange;
    logic              w_memWrEn;
    logic [ADDR_W-1:0] w_awWord;
    logic [IDX_W-1:0]  w_wrIdx;
    logic              w_unused;

    assign w_awReady   = !r_awHeld && !r_bValid;
    assign w_wReady    = !r_wHeld && !r_bValid;
    assign w_commit    = r_awHeld && r_wHeld;
    assign w_awConsole = (r_awAddr >> LSB) == (CONSOLE_ADDR >> LSB);
    assign w_awPass    = (r_awAddr >> LSB) == (PASS_ADDR >> LSB);
    assign w_awInRange = {1'b0, r_awAddr} < MEM_BYTES;
    assign w_awWord    = r_awAddr >> LSB;
    assign w_wrIdx     = IDX_W'(w_awWord % ADDR_W'(DEPTH));
    assign w_memWrEn   = w_commit && !w_awConsole && !w_awPass && (w_awInRange || !ERR_EN);
    assign w_unused    = ^{bus.mem_axi_awprot, bus.mem_axi_arprot};

    // Memory contents survive reset; only a committed, decoded write touches them.
    always_ff @(posedge clk) begin
        if (w_memWrEn) begin
            for (int b = 0; b < BYTES; b++) begin
                if (r_wStrb[b]) begin
                    r_mem[w_wrIdx][8*b +: 8] <= r_wData[8*b +: 8];
                end
            end
        end
    end

    // AW and W are captured independently; the pair commits one edge after both are held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_awHeld       <= 1'b0;
            r_awAddr       <= '0;
            r_wHeld        <= 1'b0;
            r_wData        <= '0;
            r_wStrb        <= '0;
            r_bValid       <= 1'b0;
            r_bResp        <= 2'b00;
            r_consoleValid <= 1'b0;
            r_consoleData  <= 8'h00;
            r_testsPassed  <= 1'b0;
        end else begin
            r_consoleValid <= 1'b0;
            if (bus.mem_axi_awvalid && w_awReady) begin
                r_awHeld <= 1'b1;
                r_awAddr <= bus.mem_axi_awaddr;
            end
            if (bus.mem_axi_wvalid && w_wReady) begin
                r_wHeld <= 1'b1;
                r_wData <= bus.mem_axi_wdata;
                r_wStrb <= bus.mem_axi_wstrb;
            end
            if (r_bValid && bus.mem_axi_bready) begin
                r_bValid <= 1'b0;
            end
            if (w_commit) begin
                r_awHeld <= 1'b0;
                r_wHeld  <= 1'b0;
                r_bValid <= 1'b1;
                r_bResp  <= (ERR_EN && !w_awInRange && !w_awConsole && !w_awPass) ? 2'b10 : 2'b00;
                if (w_awConsole) begin
                    r_consoleValid <= 1'b1;
                    r_consoleData  <= r_wData[7:0];
                end
                if (w_awPass && (r_wData[31:0] == PASS_MAGIC)) begin
                    r_testsPassed <= 1'b1;
                end
            end
        end
    end

    rState_t           r_rState;
    rState_t           w_rNext;
    logic [CNT_W-1:0]  r_rCnt;
    logic [DATA_W-1:0] r_rData;
    logic [1:0]        r_rResp;
    logic              w_arReady;
    logic              w_rValid;
    logic              w_arHs;
    logic              w_arMmio;
    logic              w_arInRange;
    logic [ADDR_W-1:0] w_arWord;
    logic [IDX_W-1:0]  w_rdIdx;

    assign w_arHs      = bus.mem_axi_arvalid && w_arReady;
    assign w_arMmio    = ((bus.mem_axi_araddr >> LSB) == (CONSOLE_ADDR >> LSB)) ||
                         ((bus.mem_axi_araddr >> LSB) == (PASS_ADDR >> LSB));
    assign w_arInRange = {1'b0, bus.mem_axi_araddr} < MEM_BYTES;
    assign w_arWord    = bus.mem_axi_araddr >> LSB;
    assign w_rdIdx     = IDX_W'(w_arWord % ADDR_W'(DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rState <= R_IDLE;
        end else begin
            r_rState <= w_rNext;
        end
    end

    always_comb begin
        w_rNext   = r_rState;
        w_arReady = 1'b0;
        w_rValid  = 1'b0;
        case (r_rState)
            R_IDLE: begin
                w_arReady = 1'b1;
                if (bus.mem_axi_arvalid) begin
                    w_rNext = (READ_LAT == 1) ? R_RESP : R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_rCnt == '0) begin
                    w_rNext = R_RESP;
                end
            end
            R_RESP: begin
                w_rValid = 1'b1;
                if (bus.mem_axi_rready) begin
                    w_rNext = R_IDLE;
                end
            end
            default: w_rNext = R_IDLE;
        endcase
    end

    // Data is sampled at the AR handshake edge, so a write committing on that edge is not seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rCnt  <= '0;
            r_rData <= '0;
            r_rResp <= 2'b00;
        end else begin
            if (w_arHs) begin
                r_rCnt <= CNT_LOAD;
                if (w_arMmio || (ERR_EN && !w_arInRange)) begin
                    r_rData <= '0;
                end else begin
                    r_rData <= r_mem[w_rdIdx];
                end
                r_rResp <= (ERR_EN && !w_arInRange && !w_arMmio) ? 2'b10 : 2'b00;
            end else if (r_rState == R_WAIT && r_rCnt != '0) begin
                r_rCnt <= r_rCnt - CNT_W'(1);
            end
        end
    end

    assign bus.mem_axi_awready = w_awReady;
    assign bus.mem_axi_wready  = w_wReady;
    assign bus.mem_axi_bvalid  = r_bValid;
    assign bus.mem_axi_bresp   = r_bResp;
    assign bus.mem_axi_arready = w_arReady;
    assign bus.mem_axi_rvalid  = w_rValid;
    assign bus.mem_axi_rdata   = r_rData;
    assign bus.mem_axi_rresp   = r_rResp;
    assign console_valid       = r_consoleValid;
    assign console_data        = r_consoleData;
    assign tests_passed        = r_testsPassed;
endmodule
